// File: rtl/ristretto_trap_sequencer_if.sv
// Redirect handshake between the trap sequencer (master) and the execution control unit (slave).
interface ristretto_trap_sequencer_if #(
    parameter int AddrWidth = 32
);
    logic                 trap_req_o;
    logic                 trap_ack_i;
    logic [AddrWidth-1:0] trap_address_o;

    modport master (output trap_req_o, output trap_address_o, input trap_ack_i);
    modport slave  (input trap_req_o, input trap_address_o, output trap_ack_i);
endinterface

// File: rtl/ristretto_trap_sequencer.sv
// Trap sequencer: arbitrates exceptions, MRET and interrupts, then holds the redirect until acked.
// Optional: RISTRETTO_TCU_LOCAL_EDGE_EN makes local interrupt lines rising-edge, sticky pending bits.
module ristretto_trap_sequencer #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 32,
    parameter int NumLocalIrq = 16
) (
    input  logic                                        clk_i,
    input  logic                                        rstn_i,
    input  logic                                        priv_lvl_i,
    input  logic [AddrWidth-1:0]                        exc_pc_i,
    input  logic [AddrWidth-1:0]                        next_pc_i,
    input  logic [DataWidth-1:0]                        fault_instr_i,
    input  logic [AddrWidth-1:0]                        lsu_fault_addr_i,
    input  logic [1:0]                                  instr_exception_i,
    input  logic [1:0]                                  lsu_exception_i,
    input  logic [1:0]                                  env_exception_i,
    input  logic                                        sw_intr_i,
    input  logic                                        tim_intr_i,
    input  logic                                        ext_intr_i,
    input  logic [(NumLocalIrq > 0 ? NumLocalIrq : 1)-1:0] local_intr_i,
    input  logic                                        mstatus_mie_i,
    input  logic                                        mstatus_mpie_i,
    input  logic                                        mstatus_mpp_i,
    input  logic [16+NumLocalIrq-1:0]                   mie_bits_i,
    input  logic [AddrWidth-1:0]                        mtvec_i,
    input  logic [AddrWidth-1:0]                        mepc_i,
    ristretto_trap_sequencer_if.master                  redirect,
    output logic [16+NumLocalIrq-1:0]                   mip_o,
    output logic                                        csr_we_o,
    output logic [DataWidth-1:0]                        mcause_o,
    output logic [DataWidth-1:0]                        mtval_o,
    output logic [AddrWidth-1:0]                        mepc_o,
    output logic [2:0]                                  trap_state_o,
    output logic                                        busy_o
);
    localparam int IrqW = 16 + NumLocalIrq;

    typedef enum logic {IDLE, REQ} state_t;
    state_t state;

    logic [IrqW-1:0]      irq_pend;
    logic [IrqW-1:0]      mip_d;
    logic                 irq_hit, exc_hit, is_mret, is_irq, ev;
    logic [4:0]           irq_code, exc_code;
    logic [DataWidth-1:0] exc_tval;
    logic [AddrWidth-1:0] base, irq_tgt;

    // Interrupts are arbitrated from the registered pending view, never the raw lines.
    assign irq_pend = mstatus_mie_i ? (mip_o & mie_bits_i) : '0;
    assign base     = {mtvec_i[AddrWidth-1:2], 2'b00};

    always_comb begin
        irq_hit  = 1'b0;
        irq_code = 5'd0;
        if (irq_pend[11]) begin
            irq_hit  = 1'b1;
            irq_code = 5'd11;
        end else if (irq_pend[3]) begin
            irq_hit  = 1'b1;
            irq_code = 5'd3;
        end else if (irq_pend[7]) begin
            irq_hit  = 1'b1;
            irq_code = 5'd7;
        end else begin
            for (int i = 0; i < NumLocalIrq; i++) begin
                if (!irq_hit && irq_pend[16+i]) begin
                    irq_hit  = 1'b1;
                    irq_code = 5'(16 + i);
                end
            end
        end
    end

    always_comb begin
        exc_hit  = 1'b1;
        exc_code = 5'd0;
        exc_tval = '0;
        is_mret  = 1'b0;
        if (instr_exception_i[1]) begin
            exc_code = 5'd2;
            exc_tval = fault_instr_i;
        end else if (instr_exception_i[0]) begin
            exc_code = 5'd0;
            exc_tval = fault_instr_i;
        end else if (lsu_exception_i[0]) begin
            exc_code = 5'd4;
            exc_tval = DataWidth'(lsu_fault_addr_i);
        end else if (lsu_exception_i[1]) begin
            exc_code = 5'd6;
            exc_tval = DataWidth'(lsu_fault_addr_i);
        end else if (env_exception_i[0]) begin
            exc_code = priv_lvl_i ? 5'd11 : 5'd8;
        end else begin
            exc_hit = 1'b0;
            is_mret = env_exception_i[1];
        end
    end

    assign is_irq  = !exc_hit && !is_mret && irq_hit;
    assign ev      = exc_hit || is_mret || irq_hit;
    assign irq_tgt = (mtvec_i[1:0] == 2'b01) ? base + AddrWidth'({irq_code, 2'b00}) : base;

`ifdef RISTRETTO_TCU_LOCAL_EDGE_EN
    logic [(NumLocalIrq > 0 ? NumLocalIrq : 1)-1:0] local_prev;
    logic                                           take_now;

    assign take_now = (state == IDLE) && is_irq;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) local_prev <= '0;
        else         local_prev <= local_intr_i;
    end
`endif

    always_comb begin
        mip_d     = '0;
        mip_d[3]  = sw_intr_i;
        mip_d[7]  = tim_intr_i;
        mip_d[11] = ext_intr_i;
        for (int i = 0; i < NumLocalIrq; i++) begin
`ifdef RISTRETTO_TCU_LOCAL_EDGE_EN
            // A new edge in the same cycle as the take re-arms the line.
            mip_d[16+i] = (mip_o[16+i] & ~(take_now && irq_code == 5'(16 + i)))
                        | (local_intr_i[i] & ~local_prev[i]);
`else
            mip_d[16+i] = local_intr_i[i];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) mip_o <= '0;
        else         mip_o <= mip_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state                   <= IDLE;
            busy_o                  <= 1'b0;
            csr_we_o                <= 1'b0;
            mcause_o                <= '0;
            mtval_o                 <= '0;
            mepc_o                  <= '0;
            trap_state_o            <= '0;
            redirect.trap_req_o     <= 1'b0;
            redirect.trap_address_o <= '0;
        end else begin
            csr_we_o <= 1'b0;
            case (state)
                IDLE: if (ev) begin
                    state               <= REQ;
                    busy_o              <= 1'b1;
                    csr_we_o            <= 1'b1;
                    redirect.trap_req_o <= 1'b1;
                    if (is_mret) begin
                        // mcause/mtval keep the last trap's values.
                        redirect.trap_address_o <= mepc_i;
                        mepc_o                  <= mepc_i;
                        trap_state_o            <= {mstatus_mpie_i, 1'b1, mstatus_mpp_i};
                    end else if (is_irq) begin
                        redirect.trap_address_o <= irq_tgt;
                        mepc_o                  <= next_pc_i;
                        mcause_o                <= {1'b1, (DataWidth-6)'(0), irq_code};
                        mtval_o                 <= '0;
                        trap_state_o            <= {1'b0, mstatus_mie_i, priv_lvl_i};
                    end else begin
                        redirect.trap_address_o <= base;
                        mepc_o                  <= exc_pc_i;
                        mcause_o                <= {1'b0, (DataWidth-6)'(0), exc_code};
                        mtval_o                 <= exc_tval;
                        trap_state_o            <= {1'b0, mstatus_mie_i, priv_lvl_i};
                    end
                end
                REQ: if (redirect.trap_ack_i) begin
                    state               <= IDLE;
                    busy_o              <= 1'b0;
                    redirect.trap_req_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
